// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Summary  : Round-robin sharing of one data-memory port between the CPU
//            (port 0) and a debug/DMA loader (port 1), with a timed lock.
// Revision : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int DBITS        = 32,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic             lock0,
    input  logic             lock1,
    input  logic [DBITS-1:0] addr0,
    input  logic [DBITS-1:0] addr1,
    input  logic [DBITS-1:0] wdata0,
    input  logic [DBITS-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [DBITS-1:0] rdata,
    output logic             lock_err,
    output logic             mem_we,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    input  logic [DBITS-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_OPEN  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    localparam logic [15:0] c_lock_limit = 16'(LOCK_TIMEOUT);

    state_t      r_state;
    logic        r_prio;
    logic [15:0] r_timer;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic        r_lock_err;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_owner;
    logic        w_owner_gnt;
    logic        w_owner_lock;
    logic [15:0] w_timer_inc;

    // Grants are combinational so an accepted access reaches memory in the same cycle.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_OPEN: begin
                    if (req0 && (!req1 || !r_prio)) begin
                        w_gnt0 = 1'b1;
                    end else if (req1) begin
                        w_gnt1 = 1'b1;
                    end
                end
                ST_LOCK0: w_gnt0 = req0;
                ST_LOCK1: w_gnt1 = req1;
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    // Lock owner view: only meaningful while in ST_LOCK0/ST_LOCK1.
    assign w_owner      = (r_state == ST_LOCK1);
    assign w_owner_gnt  = w_owner ? w_gnt1 : w_gnt0;
    assign w_owner_lock = w_owner ? lock1 : lock0;
    assign w_timer_inc  = r_timer + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_OPEN;
            r_prio     <= 1'b0;
            r_timer    <= 16'd0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_lock_err <= 1'b0;
        end else begin
            r_rvalid0  <= w_gnt0 & ~we0;
            r_rvalid1  <= w_gnt1 & ~we1;
            r_lock_err <= 1'b0;
            case (r_state)
                ST_OPEN: begin
                    r_timer <= 16'd0;
                    if (w_gnt0) begin
                        r_prio <= 1'b1;
                        if (lock0) begin
                            r_state <= ST_LOCK0;
                        end
                    end else if (w_gnt1) begin
                        r_prio <= 1'b0;
                        if (lock1) begin
                            r_state <= ST_LOCK1;
                        end
                    end
                end
                ST_LOCK0, ST_LOCK1: begin
                    // An owner access always beats the timeout, so a release
                    // landing on the timeout cycle never raises lock_err.
                    if (w_owner_gnt) begin
                        r_timer <= 16'd0;
                        if (!w_owner_lock) begin
                            r_state <= ST_OPEN;
                            r_prio  <= ~w_owner;
                        end
                    end else if (w_timer_inc == c_lock_limit) begin
                        r_state    <= ST_OPEN;
                        r_prio     <= ~w_owner;
                        r_timer    <= 16'd0;
                        r_lock_err <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                default: begin
                    r_state <= ST_OPEN;
                    r_timer <= 16'd0;
                end
            endcase
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign lock_err  = r_lock_err;
    assign rdata     = mem_rdata;
    assign mem_we    = (w_gnt0 & we0) | (w_gnt1 & we1);
    assign mem_addr  = w_gnt1 ? addr1 : addr0;
    assign mem_wdata = w_gnt1 ? wdata1 : wdata0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Summary  : Directed scenarios plus randomized two-master traffic against a
//            behavioural reference model for dmem_port_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int DBITS        = 32;
    localparam int LOCK_TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0, req1, we0, we1, lock0, lock1;
    logic [DBITS-1:0] addr0, addr1, wdata0, wdata1;
    logic             gnt0, gnt1, rvalid0, rvalid1, lock_err, mem_we;
    logic [DBITS-1:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [DBITS-1:0] mem [16];
    logic             mem_loaded = 1'b0;

    // Reference model state
    int               m_owner;
    int               m_fav;
    int               m_idle;
    int               m_rv_port;
    logic [DBITS-1:0] m_rv_data;
    logic             m_err;
    logic [DBITS-1:0] shadow [16];

    dmem_port_arbiter #(
        .DBITS        (DBITS),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .lock_err  (lock_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory, one word per 4-byte slot, 16 slots.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 + i;
            mem[0]     <= 32'hDEAD_BEEF;
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[5:2]];
    end

    task automatic clear_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Which port the arbitration rules pick for the given requests (-1 = none).
    function automatic int m_pick(input logic r0, input logic r1);
        if (m_owner == 0) return r0 ? 0 : -1;
        if (m_owner == 1) return r1 ? 1 : -1;
        if (r0 && r1) return m_fav;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic m_commit(input int g);
        logic             w, lk;
        logic [DBITS-1:0] a, d;
        w  = (g == 1) ? we1 : we0;
        lk = (g == 1) ? lock1 : lock0;
        a  = (g == 1) ? addr1 : addr0;
        d  = (g == 1) ? wdata1 : wdata0;
        m_err     = 1'b0;
        m_rv_port = -1;
        if (g >= 0) begin
            if (w) shadow[a[5:2]] = d;
            else begin
                m_rv_port = g;
                m_rv_data = shadow[a[5:2]];
            end
        end
        if (m_owner < 0) begin
            if (g >= 0) begin
                m_fav = 1 - g;
                if (lk) begin
                    m_owner = g;
                    m_idle  = 0;
                end
            end
        end else if (g == m_owner) begin
            m_idle = 0;
            if (!lk) begin
                m_fav   = 1 - m_owner;
                m_owner = -1;
            end
        end else begin
            m_idle++;
            if (m_idle == LOCK_TIMEOUT) begin
                m_fav   = 1 - m_owner;
                m_owner = -1;
                m_idle  = 0;
                m_err   = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h100; wdata0 = 32'hDEAD_BEEF;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h104; wdata1 = 32'h0BAD_0BAD;
        #2;
        checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
        checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b want 00", rvalid0, rvalid1); end
        checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL reset_lock_err: got %b want 0", lock_err); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (gnt0 !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_held: gnt0=%b mem_we=%b want 0 0", gnt0, mem_we); end
        reset = 1'b0;
        #1;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_first_tie: gnt=%b%b want gnt0", gnt1, gnt0); end
        checks++; if (mem_addr !== 32'h100 || mem_we !== 1'b1) begin errors++; $display("FAIL reset_first_mem: addr=%h we=%b want 100 1", mem_addr, mem_we); end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_single_read();
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt: gnt1,gnt0=%b%b want 01", gnt1, gnt0); end
        checks++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin errors++; $display("FAIL single_mem: addr=%h we=%b want 100 0", mem_addr, mem_we); end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        checks++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin errors++; $display("FAIL single_rvalid: rvalid1,rvalid0=%b%b want 01", rvalid1, rvalid0); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", rdata); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL single_rvalid_pulse: got %b want 0", rvalid0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention();
        logic             exp0;
        logic [DBITS-1:0] ea;
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h24;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp0 = ((k % 2) == 0);
            ea   = exp0 ? 32'h10 : 32'h24;
            checks++; if (gnt0 !== exp0 || gnt1 !== !exp0) begin errors++; $display("FAIL contention_gnt k=%0d: gnt1,gnt0=%b%b want %b%b", k, gnt1, gnt0, !exp0, exp0); end
            checks++; if (mem_addr !== ea) begin errors++; $display("FAIL contention_addr k=%0d: got %h want %h", k, mem_addr, ea); end
            if (k > 0) begin
                checks++; if (rvalid0 !== !exp0 || rvalid1 !== exp0) begin errors++; $display("FAIL contention_rvalid k=%0d: rvalid1,rvalid0=%b%b want %b%b", k, rvalid1, rvalid0, exp0, !exp0); end
            end
            @(posedge clk);
            #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        checks++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0) begin errors++; $display("FAIL contention_last_rvalid: rvalid1,rvalid0=%b%b want 10", rvalid1, rvalid0); end
        checks++; if (rdata !== 32'hA5A5_0009) begin errors++; $display("FAIL contention_rdata: got %h want a5a50009", rdata); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock();
        do_reset();
        req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 32'h30; wdata1 = 32'h1234_5678;
        @(negedge clk);
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL lock_entry_gnt: gnt1,gnt0=%b%b want 10", gnt1, gnt0); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h30 || mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL lock_entry_mem: we=%b addr=%h wdata=%h want 1 30 12345678", mem_we, mem_addr, mem_wdata); end
        @(posedge clk);
        #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h08;
        we1 = 1'b0; addr1 = 32'h34;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin errors++; $display("FAIL lock_hold k=%0d: gnt1,gnt0=%b%b want 10", k, gnt1, gnt0); end
            @(posedge clk);
            #1;
        end
        req1 = 1'b0;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL lock_owner_idle: gnt1,gnt0=%b%b want 00", gnt1, gnt0); end
        @(posedge clk);
        #1;
        req1 = 1'b1; lock1 = 1'b0;
        @(negedge clk);
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL lock_release_access: gnt1,gnt0=%b%b want 10", gnt1, gnt0); end
        @(posedge clk);
        #1;
        req1 = 1'b0;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1 || mem_addr !== 32'h08) begin errors++; $display("FAIL lock_after_release: gnt0=%b addr=%h want 1 08", gnt0, mem_addr); end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 32'h40;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL timeout_entry: gnt0=%b want 1", gnt0); end
        @(posedge clk);
        #1;
        req0 = 1'b0; lock0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h44;
        for (int k = 1; k <= LOCK_TIMEOUT; k++) begin
            @(negedge clk);
            checks++; if (gnt1 !== 1'b0 || lock_err !== 1'b0) begin errors++; $display("FAIL timeout_wait k=%0d: gnt1=%b lock_err=%b want 0 0", k, gnt1, lock_err); end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++; if (lock_err !== 1'b1) begin errors++; $display("FAIL timeout_lock_err: got %b want 1", lock_err); end
        checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL timeout_gnt1: got %b want 1", gnt1); end
        @(posedge clk);
        #1;
        req1 = 1'b0;
        @(negedge clk);
        checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got %b want 0", lock_err); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_release_on_timeout();
        do_reset();
        req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 32'h48;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rel_to_entry: gnt0=%b want 1", gnt0); end
        @(posedge clk);
        #1;
        req0 = 1'b0; lock0 = 1'b0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4C; wdata1 = 32'h5555_AAAA;
        for (int k = 1; k < LOCK_TIMEOUT; k++) begin
            @(negedge clk);
            checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL rel_to_stall k=%0d: gnt1=%b want 0", k, gnt1); end
            @(posedge clk);
            #1;
        end
        req0 = 1'b1; lock0 = 1'b0;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL rel_to_owner_access: gnt1,gnt0=%b%b want 01", gnt1, gnt0); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL rel_to_lock_err: got %b want 0", lock_err); end
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL rel_to_open_prio: gnt1,gnt0=%b%b want 10", gnt1, gnt0); end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL arst_first_read: gnt0=%b want 1", gnt0); end
        @(posedge clk);
        #1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h50; wdata1 = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if (rvalid0 !== 1'b1 || gnt1 !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL arst_pre: rvalid0=%b gnt1=%b mem_we=%b want 1 1 1", rvalid0, gnt1, mem_we); end
        #1 reset = 1'b1;
        #1;
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL arst_gnt_drop: gnt1,gnt0=%b%b want 00", gnt1, gnt0); end
        checks++; if (rvalid0 !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL arst_out_drop: rvalid0=%b mem_we=%b want 0 0", rvalid0, mem_we); end
        @(posedge clk);
        @(negedge clk);
        we1 = 1'b0;
        #1 reset = 1'b0;
        #1;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL arst_first_tie: gnt1,gnt0=%b%b want 01", gnt1, gnt0); end
        // Re-assert before the edge so the read just granted never completes.
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        #2;
        checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL arst_pending_dropped: rvalid0=%b want 0", rvalid0); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL arst_rvalid_quiet: rvalid1,rvalid0=%b%b want 00", rvalid1, rvalid0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit               act     [2];
        logic             rq_we   [2];
        logic             rq_lk   [2];
        logic [DBITS-1:0] rq_addr [2];
        logic [DBITS-1:0] rq_wd   [2];
        int               g;
        int               last_g;
        logic             exp_we;
        logic [DBITS-1:0] exp_addr;
        do_reset();
        m_owner = -1; m_fav = 0; m_idle = 0; m_rv_port = -1; m_err = 1'b0; m_rv_data = '0;
        for (int i = 0; i < 16; i++) shadow[i] = mem[i];
        act[0] = 1'b0; act[1] = 1'b0;
        last_g = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!act[p] || last_g == p) begin
                    act[p]     = ($urandom_range(0, 99) < 60);
                    rq_we[p]   = 1'($urandom_range(0, 1));
                    rq_lk[p]   = ($urandom_range(0, 3) == 0);
                    rq_addr[p] = $urandom & 32'hFFFF_FFFC;
                    rq_wd[p]   = $urandom;
                end
            end
            req0 = act[0]; we0 = rq_we[0]; lock0 = rq_lk[0]; addr0 = rq_addr[0]; wdata0 = rq_wd[0];
            req1 = act[1]; we1 = rq_we[1]; lock1 = rq_lk[1]; addr1 = rq_addr[1]; wdata1 = rq_wd[1];
            @(negedge clk);
            g        = m_pick(req0, req1);
            exp_we   = (g == 0) ? we0 : ((g == 1) ? we1 : 1'b0);
            exp_addr = (g == 1) ? addr1 : addr0;
            checks++; if (gnt0 !== (g == 0) || gnt1 !== (g == 1)) begin errors++; $display("FAIL rnd_gnt cyc=%0d: gnt1,gnt0=%b%b want %b%b", cyc, gnt1, gnt0, g == 1, g == 0); end
            checks++; if (mem_we !== exp_we) begin errors++; $display("FAIL rnd_mem_we cyc=%0d: got %b want %b", cyc, mem_we, exp_we); end
            checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL rnd_mem_addr cyc=%0d: got %h want %h", cyc, mem_addr, exp_addr); end
            if (exp_we) begin
                checks++; if (mem_wdata !== ((g == 1) ? wdata1 : wdata0)) begin errors++; $display("FAIL rnd_mem_wdata cyc=%0d: got %h", cyc, mem_wdata); end
            end
            checks++; if (rvalid0 !== (m_rv_port == 0) || rvalid1 !== (m_rv_port == 1)) begin errors++; $display("FAIL rnd_rvalid cyc=%0d: rvalid1,rvalid0=%b%b want %b%b", cyc, rvalid1, rvalid0, m_rv_port == 1, m_rv_port == 0); end
            if (m_rv_port >= 0) begin
                checks++; if (rdata !== m_rv_data) begin errors++; $display("FAIL rnd_rdata cyc=%0d: got %h want %h", cyc, rdata, m_rv_data); end
            end
            checks++; if (lock_err !== m_err) begin errors++; $display("FAIL rnd_lock_err cyc=%0d: got %b want %b", cyc, lock_err, m_err); end
            @(posedge clk);
            m_commit(g);
            last_g = g;
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_timeout();
        test_release_on_timeout();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
